fetch_pc_sequencer: RTL and testbench

- Owns the architectural fetch PC register and sequences instruction-memory requests.
- Tracks in-order outstanding requests and buffers responses for decode.
- On a redirect (branch mispredict / exception flush), kills in-flight fetches.
- Sits between the next-PC logic / BTB lookup and decode. Replaces ad-hoc PC equality checks with an explicit kill count, so a redirect always takes effect even when the target equals the current PC.

---
 rtl/fetch_pc_sequencer.sv | 130 +++++++++++++
 tb/tb_fetch_pc_sequencer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_sequencer.sv
// fetch_pc_sequencer
//   Owns the fetch PC, issues in-order instruction-memory requests under a
//   credit limit, buffers returning instructions for decode, and kills
//   in-flight fetches on a redirect using an explicit kill count.
//
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   redirectValid/Pc    one-cycle flush and restart at redirectPc
//   predTaken/predPc    BTB prediction for the current pcOut
//   pcOut               current fetch PC
//   imemReq*            request channel (valid/ready, address = pcOut)
//   imemResp*           in-order response channel, no backpressure
//   fetch*              head of the response buffer toward decode
module fetch_pc_sequencer #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    INSN_WIDTH = 32,
  parameter int                    DEPTH      = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirectValid,
  input  logic [ADDR_WIDTH-1:0] redirectPc,
  input  logic                  predTaken,
  input  logic [ADDR_WIDTH-1:0] predPc,
  output logic [ADDR_WIDTH-1:0] pcOut,
  output logic                  imemReqValid,
  input  logic                  imemReqReady,
  output logic [ADDR_WIDTH-1:0] imemReqAddr,
  input  logic                  imemRespValid,
  input  logic [INSN_WIDTH-1:0] imemRespData,
  output logic                  fetchValid,
  output logic [ADDR_WIDTH-1:0] fetchPc,
  output logic [INSN_WIDTH-1:0] fetchInsn,
  input  logic                  fetchReady
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic [0:0] {FETCH, DRAIN} state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [INSN_WIDTH-1:0] insn;
  } fetch_entry_t;

  state_t                             state;
  logic [ADDR_WIDTH-1:0]              pc;
  logic [CW-1:0]                      outstanding, kill_count, buf_count;
  logic [PW-1:0]                      aq_wr, aq_rd, rb_wr, rb_rd;
  logic [DEPTH-1:0][ADDR_WIDTH-1:0]   aq;
  fetch_entry_t [DEPTH-1:0]           rb;

  logic          credit, issue, resp, killed, push, pop;
  logic [CW-1:0] kill_next;

  // Outstanding plus buffered never exceeds DEPTH, so every response has a slot.
  assign credit = ({1'b0, outstanding} + {1'b0, buf_count}) < (CW+1)'(DEPTH);

  assign pcOut        = pc;
  assign imemReqAddr  = pc;
  // Reset state is FETCH with full credit, so gate explicitly while in reset.
  assign imemReqValid = rst && (state == FETCH) && credit && !redirectValid;
  assign fetchValid   = rst && (buf_count != '0);
  assign fetchPc      = rb[rb_rd].pc;
  assign fetchInsn    = rb[rb_rd].insn;

  assign issue  = imemReqValid && imemReqReady;
  // A stray response with nothing outstanding is ignored so counters cannot wrap.
  assign resp   = imemRespValid && (outstanding != '0);
  assign killed = resp && (kill_count != '0);
  // A redirect also discards a same-cycle response that would have been buffered.
  assign push   = resp && !killed && !redirectValid;
  assign pop    = fetchValid && fetchReady;

  // Every request still unreturned after this cycle belongs to the old stream.
  // Already-killed ones are part of that total, so re-redirects never double count.
  assign kill_next = outstanding - CW'(resp);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      outstanding <= '0;
      kill_count  <= '0;
      buf_count   <= '0;
      aq_wr       <= '0;
      aq_rd       <= '0;
      rb_wr       <= '0;
      rb_rd       <= '0;
    end else begin
      outstanding <= outstanding + CW'(issue) - CW'(resp);
      if (issue) aq_wr <= aq_wr + PW'(1);
      if (resp)  aq_rd <= aq_rd + PW'(1);

      if (redirectValid) begin
        // Retarget even when redirectPc == pc; the kill count does the flushing.
        pc         <= redirectPc;
        kill_count <= kill_next;
        state      <= (kill_next != '0) ? DRAIN : FETCH;
        buf_count  <= '0;
        rb_wr      <= '0;
        rb_rd      <= '0;
      end else begin
        if (issue) pc <= predTaken ? predPc : pc + ADDR_WIDTH'(4);
        if (killed) begin
          kill_count <= kill_count - CW'(1);
          if (kill_count == CW'(1)) state <= FETCH;
        end
        if (push) rb_wr <= rb_wr + PW'(1);
        if (pop)  rb_rd <= rb_rd + PW'(1);
        buf_count <= buf_count + CW'(push) - CW'(pop);
      end
    end
  end

  // Storage only; validity is tracked by the pointers and counters above.
  always_ff @(posedge clk) begin
    if (issue) aq[aq_wr] <= pc;
    if (push)  rb[rb_wr] <= {aq[aq_rd], imemRespData};
  end

  a_resp_without_request: assert property (
    @(posedge clk) disable iff (!rst) imemRespValid |-> (outstanding != '0));

  a_push_full_buffer: assert property (
    @(posedge clk) disable iff (!rst) push |-> (buf_count != CW'(DEPTH)));

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Bench for fetch_pc_sequencer: a latency-programmable in-order memory model,
// a tiny BTB model, and request/fetch scoreboards filled by each scenario.
module tb_fetch_pc_sequencer;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirectValid;
  logic [31:0] redirectPc;
  logic        predTaken;
  logic [31:0] predPc;
  logic [31:0] pcOut;
  logic        imemReqValid;
  logic        imemReqReady;
  logic [31:0] imemReqAddr;
  logic        imemRespValid;
  logic [31:0] imemRespData;
  logic        fetchValid;
  logic [31:0] fetchPc;
  logic [31:0] fetchInsn;
  logic        fetchReady;

  fetch_pc_sequencer #(
    .ADDR_WIDTH(32), .INSN_WIDTH(32), .DEPTH(DEPTH), .RESET_PC(32'h0)
  ) dut (
    .clk(clk), .rst(rst),
    .redirectValid(redirectValid), .redirectPc(redirectPc),
    .predTaken(predTaken), .predPc(predPc), .pcOut(pcOut),
    .imemReqValid(imemReqValid), .imemReqReady(imemReqReady), .imemReqAddr(imemReqAddr),
    .imemRespValid(imemRespValid), .imemRespData(imemRespData),
    .fetchValid(fetchValid), .fetchPc(fetchPc), .fetchInsn(fetchInsn),
    .fetchReady(fetchReady)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       mem_q[$];
  logic [31:0] exp_req[$];
  logic [31:0] exp_fetch[$];
  int          fetch_cyc[$];
  int          issue_cyc[$];

  int checks = 0, passes = 0;
  int cyc = 0, n_issue = 0, n_fetch = 0, last_issue_cyc = 0;
  int req_budget = 0, mem_lat = 1;
  logic        btb_en = 1'b0;
  logic [31:0] btb_from = '0, btb_to = '0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_addr = '0;

  function automatic logic [31:0] insn_of(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h5A5A_0000;
  endfunction

  task automatic drive_auto();
    imemReqReady = (req_budget > 0);
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imemRespValid = 1'b1;
      imemRespData  = insn_of(mem_q[0].addr);
    end else begin
      imemRespValid = 1'b0;
      imemRespData  = '0;
    end
    predTaken = btb_en && (pcOut == btb_from);
    predPc    = btb_to;
  endtask

  // One clock: drive environment inputs, sample at negedge, run the scoreboards.
  task automatic step();
    logic [31:0] e;
    drive_auto();
    @(negedge clk);
    if (prev_stall && imemReqValid) begin
      checks++;
      if (imemReqAddr !== prev_addr)
        $display("FAIL req_addr_stable got %h want %h", imemReqAddr, prev_addr);
      else passes++;
    end
    if (imemReqValid && imemReqReady) begin
      checks++;
      if (exp_req.size() == 0)
        $display("FAIL req_unexpected got %h want none", imemReqAddr);
      else begin
        e = exp_req.pop_front();
        if (imemReqAddr !== e) $display("FAIL req_addr got %h want %h", imemReqAddr, e);
        else passes++;
      end
      mem_q.push_back('{imemReqAddr, cyc + mem_lat});
      req_budget--;
      n_issue++;
      last_issue_cyc = cyc;
      issue_cyc.push_back(cyc);
    end
    if (imemRespValid) void'(mem_q.pop_front());
    if (fetchValid && fetchReady) begin
      checks++;
      if (exp_fetch.size() == 0)
        $display("FAIL fetch_unexpected got %h want none", fetchPc);
      else begin
        e = exp_fetch.pop_front();
        if ({fetchPc, fetchInsn} !== {e, insn_of(e)})
          $display("FAIL fetch got %h/%h want %h/%h", fetchPc, fetchInsn, e, insn_of(e));
        else passes++;
      end
      n_fetch++;
      fetch_cyc.push_back(cyc);
    end
    prev_stall = imemReqValid && !imemReqReady;
    prev_addr  = imemReqAddr;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_redirect(input logic [31:0] a);
    redirectValid = 1'b1;
    redirectPc    = a;
    step();
    redirectValid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; redirectValid = 1'b0; redirectPc = '0; predTaken = 1'b0; predPc = '0;
    imemReqReady = 1'b0; imemRespValid = 1'b0; imemRespData = '0; fetchReady = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (imemReqValid !== 1'b0) $display("FAIL rst_req_valid got %b want 0", imemReqValid); else passes++;
    checks++; if (fetchValid !== 1'b0) $display("FAIL rst_fetch_valid got %b want 0", fetchValid); else passes++;
    checks++; if (pcOut !== 32'h0) $display("FAIL rst_pc got %h want 00000000", pcOut); else passes++;
    rst = 1'b1;
  endtask

  task automatic test_sequential();
    n_issue = 0; n_fetch = 0; fetch_cyc.delete(); issue_cyc.delete();
    fetchReady = 1'b1; mem_lat = 1;
    for (int i = 0; i < 3; i++) begin
      exp_req.push_back(32'(i * 4));
      exp_fetch.push_back(32'(i * 4));
    end
    req_budget = 3;
    for (int i = 0; i < 30 && n_fetch < 3; i++) step();
    checks++; if (n_fetch != 3) $display("FAIL seq_count got %0d want 3", n_fetch); else passes++;
    checks++;
    if (!(fetch_cyc.size() == 3 && issue_cyc.size() == 3 && fetch_cyc[0] - issue_cyc[0] == 2))
      $display("FAIL seq_first_latency got %0d want 2",
               (fetch_cyc.size() > 0 && issue_cyc.size() > 0) ? fetch_cyc[0] - issue_cyc[0] : -1);
    else passes++;
    checks++;
    if (!(fetch_cyc.size() == 3 && fetch_cyc[2] - fetch_cyc[0] == 2))
      $display("FAIL seq_throughput got %0d want 2",
               (fetch_cyc.size() == 3) ? fetch_cyc[2] - fetch_cyc[0] : -1);
    else passes++;
    repeat (3) step();
    checks++; if (exp_req.size() != 0 || exp_fetch.size() != 0)
      $display("FAIL seq_left got %0d/%0d want 0/0", exp_req.size(), exp_fetch.size()); else passes++;
  endtask

  task automatic test_predict();
    do_redirect(32'h8);
    n_issue = 0; n_fetch = 0;
    btb_en = 1'b1; btb_from = 32'h8; btb_to = 32'h100;
    exp_req.push_back(32'h8);   exp_req.push_back(32'h100);   exp_req.push_back(32'h104);
    exp_fetch.push_back(32'h8); exp_fetch.push_back(32'h100); exp_fetch.push_back(32'h104);
    req_budget = 3;
    for (int i = 0; i < 30 && n_fetch < 3; i++) step();
    btb_en = 1'b0;
    checks++; if (n_fetch != 3) $display("FAIL pred_count got %0d want 3", n_fetch); else passes++;
    checks++; if (pcOut !== 32'h108) $display("FAIL pred_pc got %h want 00000108", pcOut); else passes++;
    checks++; if (exp_req.size() != 0 || exp_fetch.size() != 0)
      $display("FAIL pred_left got %0d/%0d want 0/0", exp_req.size(), exp_fetch.size()); else passes++;
  endtask

  task automatic test_kill();
    int r;
    n_issue = 0; n_fetch = 0; mem_lat = 3;
    exp_req.push_back(32'h108); exp_req.push_back(32'h10C);
    req_budget = 2;
    for (int i = 0; i < 20 && n_issue < 2; i++) step();
    r = cyc;
    do_redirect(32'h200);
    mem_lat = 1;
    exp_req.push_back(32'h200);
    exp_fetch.push_back(32'h200);
    req_budget = 1;
    for (int i = 0; i < 30 && n_fetch < 1; i++) step();
    repeat (3) step();
    checks++; if (n_fetch != 1) $display("FAIL kill_fetch_count got %0d want 1", n_fetch); else passes++;
    checks++; if (last_issue_cyc != r + 3)
      $display("FAIL kill_reissue_cycle got %0d want %0d", last_issue_cyc - r, 3); else passes++;
    checks++; if (exp_req.size() != 0 || exp_fetch.size() != 0)
      $display("FAIL kill_left got %0d/%0d want 0/0", exp_req.size(), exp_fetch.size()); else passes++;
  endtask

  task automatic test_same_pc();
    do_redirect(32'h40);
    n_issue = 0; n_fetch = 0; mem_lat = 2;
    exp_req.push_back(32'h40);
    req_budget = 1;
    for (int i = 0; i < 20 && n_issue < 1; i++) step();
    do_redirect(32'h40);
    mem_lat = 1;
    exp_req.push_back(32'h40);
    exp_fetch.push_back(32'h40);
    req_budget = 1;
    for (int i = 0; i < 30 && n_fetch < 1; i++) step();
    repeat (8) step();
    checks++; if (n_issue != 2) $display("FAIL same_pc_issues got %0d want 2", n_issue); else passes++;
    checks++; if (n_fetch != 1) $display("FAIL same_pc_fetches got %0d want 1", n_fetch); else passes++;
    checks++; if (exp_req.size() != 0 || exp_fetch.size() != 0)
      $display("FAIL same_pc_left got %0d/%0d want 0/0", exp_req.size(), exp_fetch.size()); else passes++;
  endtask

  task automatic test_stall();
    fetchReady = 1'b0;
    do_redirect(32'h300);
    n_issue = 0; n_fetch = 0; mem_lat = 1;
    for (int i = 0; i < 8; i++) begin
      exp_req.push_back(32'h300 + 32'(i * 4));
      exp_fetch.push_back(32'h300 + 32'(i * 4));
    end
    req_budget = 8;
    repeat (10) step();
    checks++; if (n_issue != DEPTH) $display("FAIL stall_issue_cap got %0d want %0d", n_issue, DEPTH); else passes++;
    checks++; if (fetchValid !== 1'b1) $display("FAIL stall_fetch_valid got %b want 1", fetchValid); else passes++;
    checks++; if (n_fetch != 0) $display("FAIL stall_no_pop got %0d want 0", n_fetch); else passes++;
    fetchReady = 1'b1;
    for (int i = 0; i < 60 && n_fetch < 8; i++) step();
    checks++; if (n_fetch != 8 || n_issue != 8)
      $display("FAIL stall_release got %0d/%0d want 8/8", n_fetch, n_issue); else passes++;
    checks++; if (exp_req.size() != 0 || exp_fetch.size() != 0)
      $display("FAIL stall_left got %0d/%0d want 0/0", exp_req.size(), exp_fetch.size()); else passes++;
  endtask

  task automatic test_reset_mid_drain();
    do_redirect(32'h600);
    n_issue = 0; n_fetch = 0; mem_lat = 4;
    exp_req.push_back(32'h600); exp_req.push_back(32'h604);
    req_budget = 2;
    for (int i = 0; i < 20 && n_issue < 2; i++) step();
    do_redirect(32'h700);
    checks++; if (fetchValid !== 1'b0) $display("FAIL drain_fetch_valid got %b want 0", fetchValid); else passes++;
    checks++; if (imemReqValid !== 1'b0) $display("FAIL drain_req_valid got %b want 0", imemReqValid); else passes++;
    #2 rst = 1'b0;
    #1;
    checks++; if (imemReqValid !== 1'b0) $display("FAIL midrst_req_valid got %b want 0", imemReqValid); else passes++;
    checks++; if (fetchValid !== 1'b0) $display("FAIL midrst_fetch_valid got %b want 0", fetchValid); else passes++;
    checks++; if (pcOut !== 32'h0) $display("FAIL midrst_pc got %h want 00000000", pcOut); else passes++;
    mem_q.delete();
    req_budget = 0;
    prev_stall = 1'b0;
    imemRespValid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    n_issue = 0; n_fetch = 0; mem_lat = 1;
    exp_req.push_back(32'h0);   exp_req.push_back(32'h4);
    exp_fetch.push_back(32'h0); exp_fetch.push_back(32'h4);
    req_budget = 2;
    for (int i = 0; i < 30 && n_fetch < 2; i++) step();
    repeat (6) step();
    checks++; if (n_fetch != 2) $display("FAIL postrst_fetches got %0d want 2", n_fetch); else passes++;
    checks++; if (exp_req.size() != 0 || exp_fetch.size() != 0)
      $display("FAIL postrst_left got %0d/%0d want 0/0", exp_req.size(), exp_fetch.size()); else passes++;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_predict();
    test_kill();
    test_same_pc();
    test_stall();
    test_reset_mid_drain();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

endmodule
